// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 inverse cipher: one shared round datapath, on-the-fly inverse key schedule.
// Optional AES_DEC_BACK2BACK_EN lets a new block be accepted on the same edge the result is taken.

package aes_dec_pkg;

  typedef enum logic [2:0] {IDLE, EXPAND, READY, RND_A, RND_B, DONE} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    logic [7:0] y;
    y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon_prev(input logic [7:0] rc);
    return (rc == 8'h1b) ? 8'h80 : {1'b0, rc[7:1]};
  endfunction

  // Byte 4*c+r sits in row r, column c; row r rotates right by r positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

module aes_sbox_reg (
  input  logic       clk,
  input  logic [7:0] a_i,
  output logic [7:0] q_o
);
  // NOTE: lookup registers hold pure datapath values that are always written before use, so they carry no reset.
  always_ff @(posedge clk) q_o <= aes_dec_pkg::sbox_fwd(a_i);
endmodule

module aes_inv_sbox_reg (
  input  logic       clk,
  input  logic [7:0] a_i,
  output logic [7:0] q_o
);
  always_ff @(posedge clk) q_o <= aes_dec_pkg::sbox_inv(a_i);
endmodule

module aes_128_dec_iter
  import aes_dec_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  state_e       state_q;
  logic [127:0] rk_q, k0_q, k10_q, s_q, out_data_q;
  logic [7:0]   rcon_q;
  logic [3:0]   round_q;
  logic         phase_q;
  logic         out_valid_q;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  fw0, fw1, fw2, fw3;
  logic [31:0]  iw0, iw1, iw2, iw3;
  logic [127:0] rk_fwd_d, rk_inv_d, s_next_d;
  logic [31:0]  fsb_in, fsb_out;
  logic [127:0] isb_in, isb_out;
  logic         key_fire, in_fire, out_fire;

  assign {w0, w1, w2, w3} = rk_q;

  // Forward schedule step (key expansion) and its inverse (decryption rounds).
  assign fw0 = w0 ^ fsb_out ^ {rcon_q, 24'h0};
  assign fw1 = w1 ^ fw0;
  assign fw2 = w2 ^ fw1;
  assign fw3 = w3 ^ fw2;
  assign iw3 = w3 ^ w2;
  assign iw2 = w2 ^ w1;
  assign iw1 = w1 ^ w0;
  assign iw0 = w0 ^ fsb_out ^ {rcon_q, 24'h0};
  assign rk_fwd_d = {fw0, fw1, fw2, fw3};
  assign rk_inv_d = {iw0, iw1, iw2, iw3};

  assign fsb_in = (state_q == EXPAND) ? rot_word(w3) : rot_word(iw3);
  assign isb_in = inv_shift_rows(s_q);

  for (genvar i = 0; i < 4; i++) begin : g_fsb
    aes_sbox_reg u_sbox (
      .clk (clk),
      .a_i (fsb_in[31-8*i -: 8]),
      .q_o (fsb_out[31-8*i -: 8])
    );
  end

  for (genvar i = 0; i < 16; i++) begin : g_isb
    aes_inv_sbox_reg u_inv_sbox (
      .clk (clk),
      .a_i (isb_in[127-8*i -: 8]),
      .q_o (isb_out[127-8*i -: 8])
    );
  end

  // The last round adds the cipher key directly and skips InvMixColumns.
  assign s_next_d = (round_q == 4'd10) ? (isb_out ^ k0_q)
                                       : inv_mix_columns(isb_out ^ rk_inv_d);

  assign key_ready = (state_q == IDLE) || (state_q == READY);

  always_comb begin
    // NOTE: default first so every path assigns in_ready and no latch is inferred.
    in_ready = 1'b0;
    case (state_q)
      READY: in_ready = !key_valid;
`ifdef AES_DEC_BACK2BACK_EN
      DONE:  in_ready = out_ready;
`endif
      default: in_ready = 1'b0;
    endcase
  end

  assign key_fire  = key_valid && key_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rk_q        <= '0;
      k0_q        <= '0;
      k10_q       <= '0;
      s_q         <= '0;
      rcon_q      <= 8'h01;
      round_q     <= 4'd1;
      phase_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (key_fire) begin
      rk_q    <= key;
      k0_q    <= key;
      rcon_q  <= 8'h01;
      round_q <= 4'd1;
      phase_q <= 1'b0;
      state_q <= EXPAND;
    end else if (in_fire) begin
      // Reached from READY, or from DONE when the result is taken on the same edge.
      s_q         <= in_data ^ k10_q;
      rk_q        <= k10_q;
      rcon_q      <= 8'h36;
      round_q     <= 4'd1;
      out_valid_q <= 1'b0;
      state_q     <= RND_A;
    end else begin
      case (state_q)
        EXPAND: begin
          phase_q <= !phase_q;
          if (phase_q) begin
            rk_q   <= rk_fwd_d;
            rcon_q <= xtime(rcon_q);
            if (round_q == 4'd10) begin
              k10_q   <= rk_fwd_d;
              state_q <= READY;
            end else begin
              round_q <= round_q + 4'd1;
            end
          end
        end
        RND_A: state_q <= RND_B;
        RND_B: begin
          rk_q   <= rk_inv_d;
          s_q    <= s_next_d;
          rcon_q <= rcon_prev(rcon_q);
          if (round_q == 4'd10) begin
            out_data_q  <= s_next_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            round_q <= round_q + 4'd1;
            state_q <= RND_A;
          end
        end
        DONE: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            state_q     <= READY;
          end
        end
        IDLE, READY: state_q <= state_q;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_dec_iter.sv
// Self-checking bench for aes_128_dec_iter: FIPS-197 vectors, handshake corner cases, random blocks
// against a table-based reference inverse cipher.
module tb_aes_128_dec_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid, key_ready;
  logic [127:0] key;
  logic         in_valid, in_ready;
  logic [127:0] in_data;
  logic         out_valid, out_ready;
  logic [127:0] out_data;

  int checks   = 0;
  int failures = 0;

`ifdef AES_DEC_BACK2BACK_EN
  localparam int SPACING = 21;
`else
  localparam int SPACING = 22;
`endif

  logic [7:0]  sb [256];
  logic [7:0]  isb[256];
  logic [31:0] ks [44];

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  aes_128_dec_iter dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic void model_expand(input logic [127:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) ks[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = ks[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      ks[i] = ks[i-4] ^ t;
    end
  endfunction

  function automatic logic [127:0] model_k10(input logic [127:0] k);
    model_expand(k);
    return {ks[40], ks[41], ks[42], ks[43]};
  endfunction

  function automatic logic [127:0] model_decrypt(input logic [127:0] k, input logic [127:0] ct);
    logic [7:0]   st[16];
    logic [7:0]   t[16];
    logic [7:0]   a0, a1, a2, a3, x2, x4, x8;
    logic [31:0]  w;
    logic [127:0] res;
    model_expand(k);
    for (int b = 0; b < 16; b++) begin
      w = ks[40 + b/4];
      st[b] = ct[127-8*b -: 8] ^ w[31-8*(b%4) -: 8];
    end
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*((c+r)%4)+r] = st[4*c+r];
      for (int b = 0; b < 16; b++) begin
        w = ks[4*rnd + b/4];
        st[b] = isb[t[b]] ^ w[31-8*(b%4) -: 8];
      end
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          for (int r = 0; r < 4; r++) begin
            // Row r output: 14*a[r] ^ 11*a[r+1] ^ 13*a[r+2] ^ 9*a[r+3].
            x2 = xt(a0); x4 = xt(x2); x8 = xt(x4);
            t[r] = x8 ^ x4 ^ x2;
            x2 = xt(a1); x4 = xt(x2); x8 = xt(x4);
            t[r] = t[r] ^ x8 ^ x2 ^ a1;
            x2 = xt(a2); x4 = xt(x2); x8 = xt(x4);
            t[r] = t[r] ^ x8 ^ x4 ^ a2;
            x8 = xt(xt(xt(a3)));
            t[r] = t[r] ^ x8 ^ a3;
            {a0, a1, a2, a3} = {a1, a2, a3, a0};
          end
          for (int r = 0; r < 4; r++) st[4*c+r] = t[r];
        end
      end
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = st[b];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic load_key(input logic [127:0] k);
    int n;
    @(negedge clk);
    key = k;
    key_valid = 1'b1;
    #1;
    n = 0;
    while (!key_ready && n < 200) begin @(negedge clk); #1; n++; end
    check("key_accept", key_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    key = rand128();
    n = 0;
    while (!key_ready && n < 100) begin n++; @(negedge clk); end
    check("expand_latency", n, 20);
    check("k10", dut.k10_q, model_k10(k));
  endtask

  task automatic accept_block(input logic [127:0] ct);
    int n;
    @(negedge clk);
    in_data = ct;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); #1; n++; end
    check("in_accept", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data = rand128();
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin lat++; @(negedge clk); end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 1'b0);
  endtask

  task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] exp,
                           input int stall);
    int lat;
    accept_block(ct);
    wait_out(lat);
    check({tag, "_latency"}, lat, 20);
    check({tag, "_data"}, out_data, exp);
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      check({tag, "_stall_hold"}, out_data, exp);
    end
    drain();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t         vecs[3];
    logic [127:0] k, ct, exp;
    logic [127:0] sct[4];
    logic [127:0] sexp[4];
    int           n, sent, recv, cyc, last;
    logic         in_fire, out_fire;

    build_sbox();
    vecs[0] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734};

    rst = 1'b1; key_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    key = '0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_key_ready", key_ready, 1'b1);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 128'h0);
    check("rst_k10", dut.k10_q, 128'h0);

    // Known-answer vectors.
    for (int i = 0; i < 3; i++) begin
      load_key(vecs[i].key);
      if (i == 2) check("k10_fips", dut.k10_q, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check("model_vs_table", model_decrypt(vecs[i].key, vecs[i].ct), vecs[i].pt);
      run_block("vec", vecs[i].ct, vecs[i].pt, 0);
    end

    // Output held under back-pressure.
    accept_block(vecs[2].ct);
    wait_out(n);
    check("hold_latency", n, 20);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c % 10 == 0) begin
        check("hold_data", out_data, vecs[2].pt);
        check("hold_valid", out_valid, 1'b1);
        check("hold_in_ready", in_ready, 1'b0);
        check("hold_key_ready", key_ready, 1'b0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_in_ready", in_ready, 1'b1);
    check("release_out_valid", out_valid, 1'b0);

    // Key and data offered together: key wins, no block is decrypted.
    k = rand128();
    key = k; key_valid = 1'b1;
    in_data = rand128(); in_valid = 1'b1;
    #1;
    check("prio_in_ready", in_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0; in_valid = 1'b0;
    n = 0;
    while (!key_ready && n < 100) begin n++; @(negedge clk); end
    check("prio_expand_latency", n, 20);
    check("prio_no_output", out_valid, 1'b0);
    check("prio_k10", dut.k10_q, model_k10(k));
    ct = rand128();
    run_block("prio_block", ct, model_decrypt(k, ct), 0);

    // Reset in the middle of round 5.
    accept_block(rand128());
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_key_ready", key_ready, 1'b1);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_k10", dut.k10_q, 128'h0);
    repeat (25) @(negedge clk);
    check("midrst_no_resume", out_valid, 1'b0);
    k = rand128();
    load_key(k);
    ct = rand128();
    run_block("midrst_block", ct, model_decrypt(k, ct), 0);

    // Random keys and blocks, random output stalls.
    for (int i = 0; i < 10; i++) begin
      k = rand128();
      load_key(k);
      for (int j = 0; j < 2; j++) begin
        ct = rand128();
        exp = model_decrypt(k, ct);
        run_block("rand", ct, exp, int'($urandom_range(0, 6)));
      end
    end

    // Streaming with out_ready tied high.
    k = rand128();
    load_key(k);
    for (int i = 0; i < 4; i++) begin
      sct[i] = rand128();
      sexp[i] = model_decrypt(k, sct[i]);
    end
    sent = 0; recv = 0; cyc = 0; last = -1;
    while (recv < 4 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      in_valid = (sent < 4);
      if (sent < 4) in_data = sct[sent];
      out_ready = 1'b1;
      #1;
      in_fire = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        check("stream_data", out_data, sexp[recv]);
        if (last >= 0) check("stream_spacing", cyc - last, SPACING);
        last = cyc;
        recv++;
      end
      if (in_fire) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("stream_count", recv, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_128_dec_iter.md
Name: aes_128_dec_iter

Overview:
- Iterative AES-128 decryptor (FIPS-197 inverse cipher); the receive-side counterpart of the pipelined aes_128 encryptor.
- One shared round datapath is reused for 10 rounds.
- Round keys are derived on the fly with an inverse key schedule, starting from a stored round-10 key.
- Valid/ready handshakes on key load, ciphertext input and plaintext output; sits between the link receive buffer and the plaintext consumer.

Parameters:
- None. AES-128 only; all widths are fixed.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  cipher key offered
- key_ready  out  1  block can accept a key
- key  in  128  cipher key; byte 0 is [127:120]
- in_valid  in  1  ciphertext offered
- in_ready  out  1  block can accept ciphertext
- in_data  in  128  ciphertext; byte 0 is [127:120], column-major per FIPS-197
- out_valid  out  1  plaintext available
- out_ready  in  1  consumer takes plaintext
- out_data  out  128  plaintext

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, key_ready=1, in_ready=0, out_valid=0, out_data=0, stored keys=0. Reset mid-operation aborts expansion or decryption, discards the key and returns to IDLE.
- S-box lookups use registered tables with 1-cycle latency: the shared forward S-box and a new inverse S-box module. Every step therefore takes 2 cycles: phase A issues the lookups, phase B combines the results and registers them.
- FSM states: IDLE, EXPAND, READY, RND_A, RND_B, DONE.
- IDLE
  - key_ready=1, in_ready=0.
  - key_valid&&key_ready: latch key into rk, rcon=0x01, go to EXPAND.
- EXPAND
  - 10 forward key-schedule steps, 2 cycles each: 20 cycles total.
  - rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - Afterwards k10=rk, and the cipher key is held as k0. Go to READY.
  - key_ready=0 and in_ready=0 throughout.
- READY
  - key_ready=1; in_ready = !key_valid (a key load has priority over data).
  - key handshake: re-enter EXPAND.
  - in handshake at edge E0: s = in_data ^ k10, rk = k10, rcon=0x36, round=1, go to RND_A.
- RND_A: issue InvSubBytes lookups on InvShiftRows(s), and a SubWord lookup on RotWord(rk.w3^rk.w2).
- RND_B
  - Next key: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^{rcon,24'h0}. rk=next key.
  - Then s = InvMixColumns(sub ^ rk_next) for rounds 1..9; s = sub ^ rk_next for round 10. rk_next equals k0 at round 10.
  - rcon steps backward through the sequence. Round counter is 4 bits, 1..10.
  - round<10: round++, go to RND_A. round==10: out_data=s, out_valid=1, go to DONE.
- Latency: out_valid rises after edge E20, counting the accepting edge as E0.
- DONE
  - out_data and out_valid are held stable until out_ready is seen.
  - out_valid&&out_ready: out_valid=0, go to READY.
  - in_ready=0 and key_ready=0.
- Throughput: one block per 22 cycles with out_ready tied high.
- in_valid or key_valid asserted while not ready: no effect. Inputs need not be held by the block.

Optional Feature:
- Macro: AES_DEC_BACK2BACK_EN.
- Defined: in DONE, in_ready=out_ready. An output handshake and an input handshake on the same edge load the new block and go straight to RND_A. out_valid drops for exactly 20 cycles. Throughput is one block per 21 cycles. key_ready stays 0 in DONE.
- Undefined: behaviour as described above.

Test Plan:
- Reset, then load key 000102030405060708090a0b0c0d0e0f, wait for READY, send 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid exactly 20 cycles after acceptance.
- Load key 2b7e151628aed2a6abf7158809cf4f3c -> internal k10 = d014f9a8c9ee2589e13f0cc8b6630ca6 (key_ready returns after 20 cycles). Send 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734.
- Hold out_ready=0 for 50 cycles after out_valid -> out_data stable, in_ready=0. Then out_ready=1 -> in_ready=1 on the next cycle.
- Assert key_valid and in_valid together in READY -> in_ready=0, the key is loaded, no block is decrypted. The later block decrypts under the new key.
- Assert rst at round 5 -> next cycle IDLE, out_valid=0, in_ready=0. A new key and block decrypt correctly.
- With AES_DEC_BACK2BACK_EN defined, stream 4 blocks with out_ready=1 -> outputs spaced 21 cycles apart, all correct.
